// File: rtl/tft_spi_tx.sv
// Byte-level SPI (mode 0, MSB first) transmitter for the TFT panel.
// Accepts one command/data byte per tft_transmit strobe. Chip-select stays
// low across back-to-back bytes and is released after CS_HOLD idle cycles.
module tft_spi_tx #(
    parameter int CLK_DIV = 2,   // clk cycles per SCK half-period, 1..255
    parameter int CS_HOLD = 4    // idle cycles before CS release, 0 = immediate
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       tft_transmit,
    input  logic       tft_dc,
    input  logic [7:0] tft_data,
    output logic       tft_busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    // A zero-width counter is illegal, so the hold counter keeps at least one bit.
    localparam int                HOLD_W    = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
    localparam logic [4:0]        HALF_LAST = 5'd15;

    state_t            state, state_d;
    // Bit 7 goes straight onto MOSI at accept, so only the remaining seven
    // bits need to be queued.
    logic [6:0]        shift_reg, shift_d;
    logic [7:0]        div_cnt, div_d;
    logic [4:0]        half_cnt, half_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic              busy_r, busy_d;
    logic              sck_d, mosi_d, cs_n_d, dc_d;
    logic              accept;

    // The OR with the strobe lets the requester see busy on the edge right
    // after its pulse, before busy_r has had a chance to rise.
    assign tft_busy = busy_r | tft_transmit;

    // busy_r is only ever high in SHIFT, so IDLE and HOLD are the accepting states.
    assign accept = tft_transmit && (state != SHIFT);

    // Next-state and next-output logic for the whole transmitter.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d = state;
        shift_d = shift_reg;
        div_d   = div_cnt;
        half_d  = half_cnt;
        hold_d  = hold_cnt;
        busy_d  = busy_r;
        sck_d   = spi_sck;
        mosi_d  = spi_mosi;
        cs_n_d  = spi_cs_n;
        dc_d    = spi_dc;

        unique case (state)
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_d  = '0;
                    sck_d  = ~spi_sck;
                    half_d = half_cnt + 5'd1;
                    if (half_cnt == HALF_LAST) begin
                        // SCK has just fallen after bit 0: the byte is done.
                        busy_d = 1'b0;
                        mosi_d = 1'b0;
                        hold_d = '0;
                        if (CS_HOLD > 0) begin
                            state_d = HOLD;
                        end else begin
                            cs_n_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (half_cnt[0]) begin
                        // Falling SCK: present the next bit for the following rise.
                        mosi_d  = shift_reg[6];
                        shift_d = {shift_reg[5:0], 1'b0};
                    end
                end else begin
                    div_d = div_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase

        // A new byte overrides everything above, including a hold expiring
        // on this same edge, so CS never blips high between bytes.
        if (accept) begin
            shift_d = tft_data[6:0];
            dc_d    = tft_dc;
            cs_n_d  = 1'b0;
            mosi_d  = tft_data[7];
            sck_d   = 1'b0;
            div_d   = '0;
            half_d  = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
        end
    end

    // State, counter and pin registers; reset aborts any byte in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            hold_cnt  <= '0;
            busy_r    <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_dc    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state     <= state_d;
            shift_reg <= shift_d;
            div_cnt   <= div_d;
            half_cnt  <= half_d;
            hold_cnt  <= hold_d;
            busy_r    <= busy_d;
            spi_sck   <= sck_d;
            spi_mosi  <= mosi_d;
            spi_cs_n  <= cs_n_d;
            spi_dc    <= dc_d;
        end
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench for tft_spi_tx. Instance 0 uses CLK_DIV=2/CS_HOLD=4,
// instance 1 uses CLK_DIV=1/CS_HOLD=0. A monitor rebuilds each serial byte
// from the pins; the directed steps compare it against hand-derived values.
module tb_tft_spi_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trans   [2];
    logic       dc_in   [2];
    logic [7:0] data_in [2];
    logic       busy    [2];
    logic       sck     [2];
    logic       mosi    [2];
    logic       cs_n    [2];
    logic       dcp     [2];

    int checks = 0;
    int errors = 0;

    // Monitor state, one slot per instance.
    int         cyc = 0;
    int         rises      [2];
    int         falls      [2];
    int         cs_rises   [2];
    int         first_rise [2];
    int         last_rise  [2];
    int         gap_min    [2];
    int         gap_max    [2];
    logic [7:0] rx         [2];
    logic       sck_q      [2];
    logic       cs_q       [2];

    tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .tft_transmit(trans[0]), .tft_dc(dc_in[0]), .tft_data(data_in[0]),
        .tft_busy(busy[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_cs_n(cs_n[0]), .spi_dc(dcp[0])
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .tft_transmit(trans[1]), .tft_dc(dc_in[1]), .tft_data(data_in[1]),
        .tft_busy(busy[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_cs_n(cs_n[1]), .spi_dc(dcp[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pin monitor: samples 1 time unit after each rising clk edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (sck[i] && !sck_q[i]) begin
                rx[i] = {rx[i][6:0], mosi[i]};
                rises[i]++;
                if (rises[i] == 1) begin
                    first_rise[i] = cyc;
                end else begin
                    if (cyc - last_rise[i] < gap_min[i]) gap_min[i] = cyc - last_rise[i];
                    if (cyc - last_rise[i] > gap_max[i]) gap_max[i] = cyc - last_rise[i];
                end
                last_rise[i] = cyc;
            end
            if (!sck[i] && sck_q[i]) falls[i]++;
            if (cs_n[i] && !cs_q[i]) cs_rises[i]++;
            sck_q[i] = sck[i];
            cs_q[i]  = cs_n[i];
        end
    end

    // One full byte on instance i, called and returning at a falling clk edge.
    // Returns at the first falling edge where busy is low again.
    task automatic xfer(input int i, input logic dc, input logic [7:0] data, input bit inject);
        int   n;
        int   a_cyc;
        int   div;
        logic last_cs;
        div        = (i == 0) ? 2 : 1;
        rises[i]   = 0;
        falls[i]   = 0;
        rx[i]      = 8'h00;
        gap_min[i] = 1000;
        gap_max[i] = 0;
        trans[i]   = 1'b1;
        dc_in[i]   = dc;
        data_in[i] = data;
        #1;
        check($sformatf("busy_comb%0d_%02h", i, data), busy[i], 1'b1);
        @(negedge clk);
        trans[i]   = 1'b0;
        dc_in[i]   = ~dc;
        data_in[i] = 8'h00;
        a_cyc      = cyc;
        check($sformatf("cs_low%0d_%02h", i, data), cs_n[i], 1'b0);
        check($sformatf("dc_acc%0d_%02h", i, data), dcp[i], dc);
        check($sformatf("mosi_b7_%0d_%02h", i, data), mosi[i], data[7]);
        n       = 0;
        last_cs = 1'b1;
        while (busy[i] && n < 200) begin
            if (inject && n == 10) begin
                trans[i]   = 1'b1;
                dc_in[i]   = ~dc;
                data_in[i] = 8'hFF;
            end else begin
                trans[i] = 1'b0;
            end
            last_cs = cs_n[i];
            n++;
            @(negedge clk);
        end
        trans[i] = 1'b0;
        check($sformatf("busy_len%0d_%02h", i, data), n, 16 * div);
        check($sformatf("cs_during%0d_%02h", i, data), last_cs, 1'b0);
        check($sformatf("rises%0d_%02h", i, data), rises[i], 8);
        check($sformatf("falls%0d_%02h", i, data), falls[i], 8);
        check($sformatf("rx%0d_%02h", i, data), rx[i], data);
        check($sformatf("setup%0d_%02h", i, data), first_rise[i] - a_cyc, div);
        check($sformatf("gap_min%0d_%02h", i, data), gap_min[i], 2 * div);
        check($sformatf("gap_max%0d_%02h", i, data), gap_max[i], 2 * div);
        check($sformatf("dc_hold%0d_%02h", i, data), dcp[i], dc);
        check($sformatf("mosi_end%0d_%02h", i, data), mosi[i], 1'b0);
        check($sformatf("cs_end%0d_%02h", i, data), cs_n[i], (i == 0) ? 1'b0 : 1'b1);
    endtask

    // Count falling edges until CS rises on instance 0, bounded.
    task automatic wait_cs_high(input string tag, input int exp);
        int m;
        m = 0;
        while (!cs_n[0] && m < 50) begin
            m++;
            @(negedge clk);
        end
        check(tag, m, exp);
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 2; i++) begin
            trans[i] = 1'b0; dc_in[i] = 1'b0; data_in[i] = 8'h00;
            rises[i] = 0; falls[i] = 0; cs_rises[i] = 0;
            first_rise[i] = 0; last_rise[i] = 0;
            gap_min[i] = 1000; gap_max[i] = 0; rx[i] = 8'h00;
            sck_q[i] = 1'b0; cs_q[i] = 1'b1;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_cs%0d", i), cs_n[i], 1'b1);
            check($sformatf("rst_sck%0d", i), sck[i], 1'b0);
            check($sformatf("rst_mosi%0d", i), mosi[i], 1'b0);
            check($sformatf("rst_dc%0d", i), dcp[i], 1'b0);
            check($sformatf("rst_busy%0d", i), busy[i], 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Single command byte, then the CS release after the idle hold.
        xfer(0, 1'b0, 8'hC0, 1'b0);
        wait_cs_high("cs_hold_c0", 4);

        // Strobe-then-poll requester: two bytes back to back via HOLD.
        base = cs_rises[0];
        xfer(0, 1'b0, 8'h11, 1'b0);
        xfer(0, 1'b0, 8'h29, 1'b0);
        check("cs_stay_11_29", cs_rises[0], base);
        wait_cs_high("cs_hold_29", 4);

        // Request 2 clk into HOLD switches D/C to data.
        base = cs_rises[0];
        xfer(0, 1'b0, 8'h3A, 1'b0);
        @(negedge clk);
        xfer(0, 1'b1, 8'hA5, 1'b0);
        // Request on the very edge the hold expires: accept wins.
        repeat (3) @(negedge clk);
        xfer(0, 1'b0, 8'h5A, 1'b0);
        check("cs_stay_a5_5a", cs_rises[0], base);
        wait_cs_high("cs_hold_5a", 4);

        // Strobe with 8'hFF mid-byte is ignored.
        xfer(0, 1'b0, 8'h3C, 1'b1);
        wait_cs_high("cs_hold_3c", 4);
        check("no_extra_sck", rises[0], 8);

        // Asynchronous reset during the 5th SCK high phase.
        rises[0]   = 0;
        trans[0]   = 1'b1;
        dc_in[0]   = 1'b1;
        data_in[0] = 8'hE7;
        @(negedge clk);
        trans[0] = 1'b0;
        n = 0;
        while (rises[0] < 5 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rst_mid_sck_high", sck[0], 1'b1);
        rst = 1'b0;
        #1;
        check("arst_cs", cs_n[0], 1'b1);
        check("arst_sck", sck[0], 1'b0);
        check("arst_mosi", mosi[0], 1'b0);
        check("arst_busy", busy[0], 1'b0);
        check("arst_dc", dcp[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xfer(0, 1'b1, 8'h96, 1'b0);
        wait_cs_high("cs_hold_96", 4);

        // Fastest divider, no CS hold: CS rises with busy.
        xfer(1, 1'b1, 8'h55, 1'b0);
        xfer(1, 1'b0, 8'hA3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
